sw_debounce: RTL and testbench

Multi-channel switch conditioner sitting directly upstream of `top`'s switch input: it takes the raw board slide-switch pins, synchronises them into the `clk` domain, filters mechanical bounce per channel, and presents clean levels plus single-cycle change pulses to the consuming logic. Every downstream `sw` consumer reads `db_out` rather than the raw pins.

---
 rtl/sw_debounce_pkg.sv | 13 +
 rtl/sw_debounce_chan.sv | 91 +++++++++
 rtl/sw_debounce.sv | 32 +++
 tb/tb_sw_debounce.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared types and default constants for the switch debouncer.
// Edge pulses are built only when SW_DEBOUNCE_EDGE_EN is defined.
package sw_debounce_pkg;

    typedef enum logic [0:0] {
        DB_STABLE   = 1'b0,
        DB_SETTLING = 1'b1
    } db_state_t;

    localparam int SW_WIDTH           = 4;
    localparam int SW_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/sw_debounce_chan.sv
// One switch channel: two-flop synchroniser, settle FSM with counter, edge pulses.
// Edge registers exist only when SW_DEBOUNCE_EDGE_EN is defined; otherwise rise/fall are 0.
module sw_debounce_chan
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic db_out,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             db_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        db_nxt    = db_out;
        case (state)
            DB_STABLE: begin
                cnt_nxt = '0;
                if (s2 != db_out) begin
                    // A one-cycle window needs no counting: accept on first sight.
                    if (DEBOUNCE_CYCLES == 1) begin
                        db_nxt = s2;
                    end else begin
                        state_nxt = DB_SETTLING;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            DB_SETTLING: begin
                if (s2 == db_out) begin
                    state_nxt = DB_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    db_nxt    = s2;
                    state_nxt = DB_STABLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            state  <= DB_STABLE;
            cnt    <= '0;
            db_out <= 1'b0;
        end else begin
            s1     <= sw;
            s2     <= s1;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            db_out <= db_nxt;
        end
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    // Pulses coincide with the db_out update; a reset never produces one.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= db_nxt & ~db_out;
            fall <= ~db_nxt & db_out;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel slide-switch conditioner: one independent debounce channel per pin.
// Define SW_DEBOUNCE_EDGE_EN to generate the rise/fall pulses; ports exist in both builds.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sw_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .sw     (sw[i]),
            .db_out (db_out[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce (DEBOUNCE_CYCLES=4, CNT_W=3): directed scenarios then random toggling.
// The reference model tracks, per channel, how long the synchronised input has disagreed with the output.
module tb_sw_debounce;

    localparam int W  = 4;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw  = '0;
    logic [W-1:0] db_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;

    sw_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw     (sw),
        .db_out (db_out),
        .rise   (rise),
        .fall   (fall)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected {db_out, rise, fall} after each edge, in edge order.
    logic [3*W-1:0] exp_q[$];

    // Reference model state: last two sampled inputs (oldest first), accepted level, disagreement run.
    logic [W-1:0] hist_old = '0;
    logic [W-1:0] hist_new = '0;
    logic [W-1:0] m_db     = '0;
    int           run[W];
    string        phase    = "reset";

    task automatic step(input logic [W-1:0] v, input logic r);
        logic [W-1:0] seen;
        logic [W-1:0] er;
        logic [W-1:0] ef;
        @(negedge clk);
        sw  = v;
        rst = r;
        er  = '0;
        ef  = '0;
        if (r) begin
            hist_old = '0;
            hist_new = '0;
            m_db     = '0;
            for (int c = 0; c < W; c++) run[c] = 0;
        end else begin
            // The FSM sees the input that was sampled two edges ago.
            seen     = hist_old;
            hist_old = hist_new;
            hist_new = v;
            for (int c = 0; c < W; c++) begin
                if (seen[c] != m_db[c]) begin
                    run[c]++;
                    if (run[c] == DC) begin
                        m_db[c] = seen[c];
                        er[c]   = seen[c];
                        ef[c]   = ~seen[c];
                        run[c]  = 0;
                    end
                end else begin
                    run[c] = 0;
                end
            end
        end
`ifndef SW_DEBOUNCE_EDGE_EN
        er = '0;
        ef = '0;
`endif
        exp_q.push_back({m_db, er, ef});
    endtask

    task automatic hold(input logic [W-1:0] v, input int n);
        for (int k = 0; k < n; k++) step(v, 1'b0);
    endtask

    // Monitor: every edge is an output event; compare against the oldest expectation.
    initial begin
        logic [3*W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({db_out, rise, fall} !== e) begin
                    failures++;
                    $display("FAIL %s t=%0t db_out/rise/fall actual=%b/%b/%b required=%b/%b/%b",
                             phase, $time, db_out, rise, fall,
                             e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]);
                end
            end
        end
    end

    initial begin
        for (int c = 0; c < W; c++) run[c] = 0;

        phase = "reset";
        step('0, 1'b1);
        step('0, 1'b1);
        hold('0, 10);

        phase = "clean_press";
        step('0, 1'b1);
        hold(4'b0001, 10);

        phase = "glitch";
        hold(4'b0011, 3);
        hold(4'b0001, 10);

        phase = "bounce";
        step(4'b0101, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0101, 1'b0);
        step(4'b0001, 1'b0);
        hold(4'b0101, 10);

        phase = "simultaneous";
        hold(4'b1000, 10);

        phase = "rst_mid_settle";
        hold(4'b0000, 8);
        hold(4'b0001, 2);
        step(4'b0001, 1'b1);
        hold(4'b0001, 10);

        phase = "random";
        begin
            logic [W-1:0] v;
            v = 4'b0001;
            for (int k = 0; k < 600; k++) begin
                for (int c = 0; c < W; c++)
                    if ($urandom_range(0, 5) == 0) v[c] = ~v[c];
                step(v, $urandom_range(0, 199) == 0);
            end
        end

        phase = "drain";
        hold(sw, 12);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending_expectations actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
